// File: rtl/syn_anti_alias_job_que.sv
// Anti-alias job queue: synchronous FIFO between the rasterizer and the anti-alias datapath.
// Registered pop data and registered status (empty, occupancy, sticky overflow/underflow).
module syn_anti_alias_job_que #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned X_W   = 10,
    parameter int unsigned Y_W   = 9,
    parameter int unsigned PXL_W = 8
) (
    input  logic                     clk_ir,
    input  logic                     rst_il,
    input  logic                     job_valid_i,
    input  logic [X_W-1:0]           job_x_i,
    input  logic [Y_W-1:0]           job_y_i,
    input  logic [PXL_W-1:0]         job_pxl_i,
    output logic                     job_rdy_o,
    input  logic                     deq_rd_en_i,
    output logic                     deq_valid_o,
    output logic [X_W-1:0]           deq_x_o,
    output logic [Y_W-1:0]           deq_y_o,
    output logic [PXL_W-1:0]         deq_pxl_o,
    output logic                     job_que_empty_o,
    output logic [$clog2(DEPTH):0]   job_que_occ_o,
    output logic                     ovrflw_o,
    output logic                     udrflw_o,
    input  logic                     clr_status_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = X_W + Y_W + PXL_W;

    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [OCC_W-1:0] occ_nxt;
    logic             wr_acc, rd_acc;
    logic             rdy_nxt, empty_nxt;
    logic             ovf_nxt, udf_nxt;
    logic [X_W-1:0]   deq_x_nxt;
    logic [Y_W-1:0]   deq_y_nxt;
    logic [PXL_W-1:0] deq_pxl_nxt;
    logic [ENT_W-1:0] rd_ent;

    // Accept decisions come only from registered status, so a read never frees a slot for a same-cycle write.
    always_comb begin
        wr_acc      = job_valid_i && job_rdy_o;
        rd_acc      = deq_rd_en_i && !job_que_empty_o;
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        occ_nxt     = job_que_occ_o;
        rd_ent      = mem[rd_ptr];
        deq_x_nxt   = deq_x_o;
        deq_y_nxt   = deq_y_o;
        deq_pxl_nxt = deq_pxl_o;

        if (wr_acc) begin
            wr_ptr_nxt = PTR_W'(wr_ptr + 1'b1);
        end
        if (rd_acc) begin
            rd_ptr_nxt  = PTR_W'(rd_ptr + 1'b1);
            deq_x_nxt   = rd_ent[ENT_W-1 -: X_W];
            deq_y_nxt   = rd_ent[PXL_W +: Y_W];
            deq_pxl_nxt = rd_ent[PXL_W-1:0];
        end

        case ({wr_acc, rd_acc})
            2'b10:   occ_nxt = OCC_W'(job_que_occ_o + 1'b1);
            2'b01:   occ_nxt = OCC_W'(job_que_occ_o - 1'b1);
            default: occ_nxt = job_que_occ_o;
        endcase

        rdy_nxt   = (occ_nxt != OCC_W'(DEPTH));
        empty_nxt = (occ_nxt == '0);

        // Set has priority over a same-cycle clear.
        ovf_nxt = (job_valid_i && !job_rdy_o) || (ovrflw_o && !clr_status_i);
        udf_nxt = (deq_rd_en_i && job_que_empty_o) || (udrflw_o && !clr_status_i);
    end

    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            job_que_occ_o   <= '0;
            job_que_empty_o <= 1'b1;
            job_rdy_o       <= 1'b1;
            deq_valid_o     <= 1'b0;
            deq_x_o         <= '0;
            deq_y_o         <= '0;
            deq_pxl_o       <= '0;
            ovrflw_o        <= 1'b0;
            udrflw_o        <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr_nxt;
            rd_ptr          <= rd_ptr_nxt;
            job_que_occ_o   <= occ_nxt;
            job_que_empty_o <= empty_nxt;
            job_rdy_o       <= rdy_nxt;
            deq_valid_o     <= rd_acc;
            deq_x_o         <= deq_x_nxt;
            deq_y_o         <= deq_y_nxt;
            deq_pxl_o       <= deq_pxl_nxt;
            ovrflw_o        <= ovf_nxt;
            udrflw_o        <= udf_nxt;
        end
    end

    // Storage is not reset; a stray write during reset is harmless since pointers restart.
    always_ff @(posedge clk_ir) begin
        if (wr_acc) begin
            mem[wr_ptr] <= {job_x_i, job_y_i, job_pxl_i};
        end
    end

endmodule

// File: tb/tb_syn_anti_alias_job_que.sv
// Directed bench for syn_anti_alias_job_que: reset, fill/overflow, drain order,
// simultaneous rd/wr, flag priority and a scoreboarded wrap run.
module tb_syn_anti_alias_job_que;

    logic       clk_ir = 1'b0;
    logic       rst_il;
    logic       job_valid_i;
    logic [9:0] job_x_i;
    logic [8:0] job_y_i;
    logic [7:0] job_pxl_i;
    logic       job_rdy_o;
    logic       deq_rd_en_i;
    logic       deq_valid_o;
    logic [9:0] deq_x_o;
    logic [8:0] deq_y_o;
    logic [7:0] deq_pxl_o;
    logic       job_que_empty_o;
    logic [4:0] job_que_occ_o;
    logic       ovrflw_o;
    logic       udrflw_o;
    logic       clr_status_i;

    int checks   = 0;
    int failures = 0;

    logic [26:0] q [$];
    logic [26:0] ent, exp_ent;
    logic        do_wr, do_rd;
    int          wr_n, rd_n;

    syn_anti_alias_job_que dut (
        .clk_ir          (clk_ir),
        .rst_il          (rst_il),
        .job_valid_i     (job_valid_i),
        .job_x_i         (job_x_i),
        .job_y_i         (job_y_i),
        .job_pxl_i       (job_pxl_i),
        .job_rdy_o       (job_rdy_o),
        .deq_rd_en_i     (deq_rd_en_i),
        .deq_valid_o     (deq_valid_o),
        .deq_x_o         (deq_x_o),
        .deq_y_o         (deq_y_o),
        .deq_pxl_o       (deq_pxl_o),
        .job_que_empty_o (job_que_empty_o),
        .job_que_occ_o   (job_que_occ_o),
        .ovrflw_o        (ovrflw_o),
        .udrflw_o        (udrflw_o),
        .clr_status_i    (clr_status_i)
    );

    always #5 clk_ir = ~clk_ir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [9:0] x, input logic [8:0] y,
                         input logic [7:0] p, input logic rd, input logic clr);
        job_valid_i  = v;
        job_x_i      = x;
        job_y_i      = y;
        job_pxl_i    = p;
        deq_rd_en_i  = rd;
        clr_status_i = clr;
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic tick();
        @(posedge clk_ir);
        #1;
    endtask

    initial begin
        rst_il = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst_il = 1'b0;

        // Reset: some traffic, then a one-cycle reset with traffic still applied.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10'(i + 7), 9'(i), 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        tick();
        chk("pre_rst_occ", 32'(job_que_occ_o), 32'd2);
        drive(1'b1, 10'h3AA, 9'h1AA, 8'hAA, 1'b1, 1'b0);
        rst_il = 1'b1;
        tick();
        rst_il = 1'b0;
        chk("rst_occ", 32'(job_que_occ_o), 32'd0);
        chk("rst_empty", 32'(job_que_empty_o), 32'd1);
        chk("rst_rdy", 32'(job_rdy_o), 32'd1);
        chk("rst_dv", 32'(deq_valid_o), 32'd0);
        chk("rst_data", 32'({deq_x_o, deq_y_o, deq_pxl_o}), 32'd0);
        chk("rst_flags", 32'({ovrflw_o, udrflw_o}), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        tick();
        chk("rst_udf_set", 32'(udrflw_o), 32'd1);
        chk("rst_udf_dv", 32'(deq_valid_o), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        tick();
        chk("rst_udf_clr", 32'(udrflw_o), 32'd0);

        // Fill to 16.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 10'(i), 9'(2 * i), 8'(i) ^ 8'hA5, 1'b0, 1'b0);
            tick();
            chk("fill_occ", 32'(job_que_occ_o), 32'(i + 1));
        end
        chk("full_rdy", 32'(job_rdy_o), 32'd0);
        chk("full_empty", 32'(job_que_empty_o), 32'd0);
        chk("full_ovf0", 32'(ovrflw_o), 32'd0);
        drive(1'b1, 10'h3FF, 9'h1FF, 8'hFF, 1'b0, 1'b0);
        tick();
        chk("ovf_set", 32'(ovrflw_o), 32'd1);
        chk("ovf_occ", 32'(job_que_occ_o), 32'd16);

        // Drain 16 back-to-back; first pop carries a write that must be dropped (no full-bypass).
        for (int i = 0; i < 16; i++) begin
            if (i == 0) drive(1'b1, 10'h3FE, 9'h1FE, 8'hFE, 1'b1, 1'b0);
            else        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
            tick();
            chk("drain_dv", 32'(deq_valid_o), 32'd1);
            chk("drain_x", 32'(deq_x_o), 32'(i));
            chk("drain_y", 32'(deq_y_o), 32'(2 * i));
            chk("drain_pxl", 32'(deq_pxl_o), 32'(8'(i) ^ 8'hA5));
            chk("drain_occ", 32'(job_que_occ_o), 32'(15 - i));
        end
        chk("drain_empty", 32'(job_que_empty_o), 32'd1);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        tick();
        chk("idle_dv", 32'(deq_valid_o), 32'd0);
        chk("hold_x", 32'(deq_x_o), 32'd15);
        chk("ovf_clr", 32'(ovrflw_o), 32'd0);

        // Simultaneous read/write at occ=5.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10'(10'h100 + i), 9'(i), 8'(i), 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 10'(10'h105 + k), 9'(5 + k), 8'(5 + k), 1'b1, 1'b0);
            tick();
            chk("sim_occ", 32'(job_que_occ_o), 32'd5);
            chk("sim_dv", 32'(deq_valid_o), 32'd1);
            chk("sim_x", 32'(deq_x_o), 32'(10'h100 + k));
            chk("sim_y", 32'(deq_y_o), 32'(k));
        end
        chk("sim_flags", 32'({ovrflw_o, udrflw_o}), 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
            tick();
            chk("sim_tail_x", 32'(deq_x_o), 32'(10'h10A + k));
        end
        chk("sim_tail_empty", 32'(job_que_empty_o), 32'd1);

        // Write+read at empty: write proceeds, read is an underflow.
        drive(1'b1, 10'h2C3, 9'h0C3, 8'hC3, 1'b1, 1'b0);
        tick();
        chk("e_wr_occ", 32'(job_que_occ_o), 32'd1);
        chk("e_wr_udf", 32'(udrflw_o), 32'd1);
        chk("e_wr_dv", 32'(deq_valid_o), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        tick();
        chk("e_pop_dv", 32'(deq_valid_o), 32'd1);
        chk("e_pop_x", 32'(deq_x_o), 32'h2C3);
        chk("e_pop_pxl", 32'(deq_pxl_o), 32'hC3);

        // Flag priority: clear with a fresh underflow keeps the flag set.
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
        tick();
        chk("prio_udf", 32'(udrflw_o), 32'd1);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        tick();
        chk("prio_clr", 32'(udrflw_o), 32'd0);
        chk("prio_occ", 32'(job_que_occ_o), 32'd0);

        // Wrap: random interleave against a queue model.
        wr_n = 0;
        rd_n = 0;
        for (int cyc = 0; cyc < 2000 && rd_n < 100; cyc++) begin
            do_wr = (wr_n < 100) && (q.size() < 15) && ($urandom_range(0, 1) == 1);
            do_rd = ((q.size() >= 2) || (wr_n == 100 && q.size() >= 1)) &&
                    ($urandom_range(0, 1) == 1);
            ent   = {10'($urandom), 9'($urandom), 8'($urandom)};
            drive(do_wr, ent[26:17], ent[16:8], ent[7:0], do_rd, 1'b0);
            tick();
            if (do_rd) begin
                exp_ent = q.pop_front();
                rd_n++;
                chk("wrap_dv", 32'(deq_valid_o), 32'd1);
                chk("wrap_data", 32'({deq_x_o, deq_y_o, deq_pxl_o}), 32'(exp_ent));
            end else begin
                chk("wrap_dv", 32'(deq_valid_o), 32'd0);
            end
            if (do_wr) begin
                q.push_back(ent);
                wr_n++;
            end
            chk("wrap_occ", 32'(job_que_occ_o), 32'(q.size()));
            chk("wrap_empty", 32'(job_que_empty_o), 32'(q.size() == 0));
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("wrap_reads", 32'(rd_n), 32'd100);
        chk("wrap_flags", 32'({ovrflw_o, udrflw_o}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
